// File: rtl/sync_fifo_cfg.sv
// Synchronous FIFO with programmable almost-full/almost-empty levels,
// selectable registered or first-word-fall-through read, sticky errors.
module sync_fifo_cfg #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter bit FWFT       = 1'b0,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid_s,
  input  logic [DATA_WIDTH-1:0] i_datain,
  output logic                  o_ready_s,
  input  logic                  i_ready_m,
  output logic                  o_valid_m,
  output logic [DATA_WIDTH-1:0] o_dataout,
  input  logic [ADDR_WIDTH:0]   i_almostfull_lvl,
  input  logic [ADDR_WIDTH:0]   i_almostempty_lvl,
  output logic                  o_full,
  output logic                  o_almostfull,
  output logic                  o_empty,
  output logic                  o_almostempty,
  output logic [ADDR_WIDTH:0]   o_count,
  input  logic                  i_flush,
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_clr_err
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  assign o_full        = (o_count == DEPTH_C);
  assign o_empty       = (o_count == '0);
  assign o_almostfull  = (o_count >= i_almostfull_lvl);
  assign o_almostempty = (o_count <= i_almostempty_lvl);
  assign o_ready_s     = ~o_full;

  assign wr_en = i_valid_s & ~o_full;
  assign rd_en = i_ready_m & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= i_datain;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && !rd_en) begin
        o_count <= o_count + CNT_ONE;
      end else if (rd_en && !wr_en) begin
        o_count <= o_count - CNT_ONE;
      end
    end
  end

  // set beats clear; flush leaves the error history alone
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_valid_s && o_full) begin
        o_overflow <= 1'b1;
      end else if (i_clr_err) begin
        o_overflow <= 1'b0;
      end
      if (i_ready_m && o_empty) begin
        o_underflow <= 1'b1;
      end else if (i_clr_err) begin
        o_underflow <= 1'b0;
      end
    end
  end

  if (FWFT) begin : g_fwft
    assign o_valid_m = ~o_empty;
    assign o_dataout = mem[rd_ptr];
  end else begin : g_reg
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        o_valid_m <= 1'b0;
        o_dataout <= '0;
      end else begin
        o_valid_m <= rd_en & ~i_flush;
        if (rd_en && !i_flush) begin
          o_dataout <= mem[rd_ptr];
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Directed bench for sync_fifo_cfg: depth 8, width 8, levels 6/2,
// one instance per read mode.
module tb_sync_fifo_cfg;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // registered-read instance
  logic       rst0, v0, r0, fl0, clr0;
  logic [7:0] d0, q0;
  logic [3:0] afl0, ael0, cnt0;
  logic       rdy0, vm0, full0, af0, emp0, ae0, ovf0, unf0;

  // fall-through instance
  logic       rst1, v1, r1, fl1, clr1;
  logic [7:0] d1, q1;
  logic [3:0] afl1, ael1, cnt1;
  logic       rdy1, vm1, full1, af1, emp1, ae1, ovf1, unf1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_d;

  sync_fifo_cfg #(
    .FIFO_DEPTH(8), .DATA_WIDTH(8), .FWFT(1'b0)
  ) u_dut0 (
    .i_clk(clk), .i_rst(rst0),
    .i_valid_s(v0), .i_datain(d0), .o_ready_s(rdy0),
    .i_ready_m(r0), .o_valid_m(vm0), .o_dataout(q0),
    .i_almostfull_lvl(afl0), .i_almostempty_lvl(ael0),
    .o_full(full0), .o_almostfull(af0),
    .o_empty(emp0), .o_almostempty(ae0),
    .o_count(cnt0), .i_flush(fl0),
    .o_overflow(ovf0), .o_underflow(unf0),
    .i_clr_err(clr0)
  );

  sync_fifo_cfg #(
    .FIFO_DEPTH(8), .DATA_WIDTH(8), .FWFT(1'b1)
  ) u_dut1 (
    .i_clk(clk), .i_rst(rst1),
    .i_valid_s(v1), .i_datain(d1), .o_ready_s(rdy1),
    .i_ready_m(r1), .o_valid_m(vm1), .o_dataout(q1),
    .i_almostfull_lvl(afl1), .i_almostempty_lvl(ael1),
    .o_full(full1), .o_almostfull(af1),
    .o_empty(emp1), .o_almostempty(ae1),
    .o_count(cnt1), .i_flush(fl1),
    .o_overflow(ovf1), .o_underflow(unf1),
    .i_clr_err(clr1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {v0, r0, fl0, clr0, d0} = '0;
    {v1, r1, fl1, clr1, d1} = '0;
    afl0 = 4'd6; ael0 = 4'd2;
    afl1 = 4'd6; ael1 = 4'd2;
    rst0 = 1'b1; rst1 = 1'b1;
    tick();
    tick();
    rst0 = 1'b0; rst1 = 1'b0;

    chk("rst_cnt",  32'(cnt0), 0);
    chk("rst_emp",  32'(emp0), 1);
    chk("rst_full", 32'(full0), 0);
    chk("rst_ae",   32'(ae0), 1);
    chk("rst_af",   32'(af0), 0);
    chk("rst_vm",   32'(vm0), 0);
    chk("rst_q",    32'(q0), 0);
    chk("rst_ovf",  32'(ovf0), 0);
    chk("rst_unf",  32'(unf0), 0);
    chk("rst_rdy",  32'(rdy0), 1);
    afl0 = 4'd0;
    #1;
    chk("rst_af_lvl0", 32'(af0), 1);
    afl0 = 4'd6;

    // fill
    for (int i = 1; i <= 8; i++) begin
      v0 = 1'b1; d0 = 8'(i);
      tick();
      chk("fill_cnt", 32'(cnt0), i);
      chk("fill_af",  32'(af0), (i >= 6) ? 1 : 0);
    end
    chk("fill_full", 32'(full0), 1);
    chk("fill_rdy",  32'(rdy0), 0);
    afl0 = 4'd9; ael0 = 4'd15;
    #1;
    chk("lvl_hi_af", 32'(af0), 0);
    chk("lvl_hi_ae", 32'(ae0), 1);
    afl0 = 4'd6; ael0 = 4'd2;
    d0 = 8'h09;
    tick();
    v0 = 1'b0;
    chk("ovf_set", 32'(ovf0), 1);
    chk("ovf_cnt", 32'(cnt0), 8);

    // drain, registered read
    r0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("drain_vm",  32'(vm0), 1);
      chk("drain_q",   32'(q0), i);
      chk("drain_cnt", 32'(cnt0), 8 - i);
    end
    chk("drain_emp", 32'(emp0), 1);
    tick();
    r0 = 1'b0;
    chk("unf_set",  32'(unf0), 1);
    chk("unf_vm",   32'(vm0), 0);
    chk("unf_hold", 32'(q0), 8);

    // simultaneous write+read at empty is write-only
    v0 = 1'b1; r0 = 1'b1; d0 = 8'h11;
    tick();
    r0 = 1'b0;
    chk("wr_rd_0_cnt", 32'(cnt0), 1);
    chk("wr_rd_0_vm",  32'(vm0), 0);
    for (int i = 2; i <= 8; i++) begin
      d0 = 8'h10 + 8'(i);
      tick();
    end
    chk("refill_cnt", 32'(cnt0), 8);
    // at full it is read-only
    r0 = 1'b1; d0 = 8'h99;
    tick();
    v0 = 1'b0;
    chk("wr_rd_8_cnt", 32'(cnt0), 7);
    chk("wr_rd_8_q",   32'(q0), 32'h11);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("to4_q", 32'(q0), 32'h10 + i);
    end
    r0 = 1'b0;
    chk("to4_cnt", 32'(cnt0), 4);
    exp_q = '{8'h15, 8'h16, 8'h17, 8'h18};

    // steady write+read at count 4 across pointer wrap
    for (int i = 0; i < 20; i++) begin
      v0 = 1'b1; r0 = 1'b1;
      d0 = 8'($urandom_range(255));
      exp_q.push_back(d0);
      exp_d = exp_q.pop_front();
      tick();
      chk("wrap_q",   32'(q0), 32'(exp_d));
      chk("wrap_cnt", 32'(cnt0), 4);
    end
    r0 = 1'b0;
    d0 = 8'h55;
    tick();
    v0 = 1'b0;
    chk("pre_fl_cnt", 32'(cnt0), 5);

    // flush wins over same-cycle write and read
    fl0 = 1'b1; v0 = 1'b1; r0 = 1'b1; d0 = 8'hEE;
    tick();
    fl0 = 1'b0; v0 = 1'b0; r0 = 1'b0;
    chk("fl_cnt", 32'(cnt0), 0);
    chk("fl_emp", 32'(emp0), 1);
    chk("fl_vm",  32'(vm0), 0);
    chk("fl_ovf", 32'(ovf0), 1);
    chk("fl_unf", 32'(unf0), 1);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("clr_ovf", 32'(ovf0), 0);
    chk("clr_unf", 32'(unf0), 0);
    v0 = 1'b1; d0 = 8'h77;
    tick();
    v0 = 1'b0; r0 = 1'b1;
    tick();
    r0 = 1'b0;
    chk("post_fl_q", 32'(q0), 32'h77);

    // reset mid-stream with a pending output
    r0 = 1'b1;
    tick();
    r0 = 1'b0;
    chk("unf_again", 32'(unf0), 1);
    v0 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d0 = 8'hA0 + 8'(i);
      tick();
    end
    v0 = 1'b0; r0 = 1'b1;
    tick();
    r0 = 1'b0;
    chk("pre_rst_vm",  32'(vm0), 1);
    chk("pre_rst_q",   32'(q0), 32'hA1);
    chk("pre_rst_cnt", 32'(cnt0), 3);
    rst0 = 1'b1; v0 = 1'b1; r0 = 1'b1; clr0 = 1'b1;
    tick();
    rst0 = 1'b0; v0 = 1'b0; r0 = 1'b0; clr0 = 1'b0;
    chk("mid_rst_cnt", 32'(cnt0), 0);
    chk("mid_rst_emp", 32'(emp0), 1);
    chk("mid_rst_vm",  32'(vm0), 0);
    chk("mid_rst_q",   32'(q0), 0);
    chk("mid_rst_unf", 32'(unf0), 0);
    chk("mid_rst_ovf", 32'(ovf0), 0);
    chk("mid_rst_ae",  32'(ae0), 1);
    chk("mid_rst_af",  32'(af0), 0);

    // fall-through mode
    chk("fw_rst_vm", 32'(vm1), 0);
    chk("fw_rst_emp", 32'(emp1), 1);
    v1 = 1'b1; d1 = 8'hA5;
    tick();
    v1 = 1'b0;
    chk("fw_vm",  32'(vm1), 1);
    chk("fw_q",   32'(q1), 32'hA5);
    chk("fw_cnt", 32'(cnt1), 1);
    r1 = 1'b1;
    tick();
    r1 = 1'b0;
    chk("fw_pop_emp", 32'(emp1), 1);
    chk("fw_pop_vm",  32'(vm1), 0);
    v1 = 1'b1; d1 = 8'h10;
    tick();
    d1 = 8'h20;
    tick();
    v1 = 1'b0;
    chk("fw_head1", 32'(q1), 32'h10);
    r1 = 1'b1;
    tick();
    r1 = 1'b0;
    chk("fw_head2", 32'(q1), 32'h20);
    chk("fw_cnt2",  32'(cnt1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
